// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx
//   Memory-mapped 8N1 UART transmitter on the core data bus.
//   Bytes written to p_DATA_ADDR are queued in a TX FIFO.
//   The transmit FSM takes them from the FIFO and sends them on o_tx.
//   Reads return registered data one cycle after the address, as data memory does.
//
// Ports
//   i_clk, i_rst     system clock, synchronous active-high reset
//   i_mem_addr       bus address (16)
//   i_mem_wr_data    bus write data (16); only [7:0] is used for TX bytes
//   i_mem_wr_en      bus write strobe
//   o_mem_rd_data    registered read data (16), valid when o_rd_valid
//   o_rd_valid       the previous cycle's address hit DATA or STAT
//   o_tx             UART serial line, idle high
//   o_busy           FIFO non-empty or frame in progress
//
// Bus handshake: there is no stall. A write is taken on the edge where
// i_mem_wr_en is high. A read address presented before edge N yields
// o_rd_valid/o_mem_rd_data after edge N, for exactly one cycle.
//
// Register map
//   DATA  write: enqueue byte      read: FIFO count (0..p_FIFO_DEPTH)
//   STAT  write: clear overflow    read: {12'b0, ovf, busy, empty, full}
module mmio_uart_tx #(
   parameter int          p_CLK_DIV    = 434,
   parameter int          p_FIFO_DEPTH = 16,
   parameter logic [15:0] p_DATA_ADDR  = 16'hFFFE,
   parameter logic [15:0] p_STAT_ADDR  = 16'hFFFD
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [15:0] i_mem_addr,
   input  logic [15:0] i_mem_wr_data,
   input  logic        i_mem_wr_en,
   output logic [15:0] o_mem_rd_data,
   output logic        o_rd_valid,
   output logic        o_tx,
   output logic        o_busy
);

   localparam int c_AW = $clog2(p_FIFO_DEPTH);
   localparam int c_CW = (p_CLK_DIV > 2) ? $clog2(p_CLK_DIV) : 1;
   localparam logic [c_AW:0]   c_DEPTH     = (c_AW+1)'(p_FIFO_DEPTH);
   localparam logic [c_CW-1:0] c_BAUD_LAST = c_CW'(p_CLK_DIV - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t          state_q, state_d;
   logic [c_CW-1:0] baud_q, baud_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic [7:0]      shift_q, shift_d;
   logic            tx_q, tx_d;
   logic [c_AW:0]   wr_ptr_q, wr_ptr_d;
   logic [c_AW:0]   rd_ptr_q, rd_ptr_d;
   logic            ovf_q, ovf_d;
   logic            rd_valid_q, rd_valid_d;
   logic [15:0]     rd_data_q, rd_data_d;

   logic [7:0]      fifo_mem [p_FIFO_DEPTH];

   logic [c_AW:0]   count;
   logic            empty, full, busy;
   logic            pop, push, wr_hit, stat_wr, ovf_set, baud_last;
   logic            unused_wr_hi;

   // Only the low byte is transmitted.
   assign unused_wr_hi = ^i_mem_wr_data[15:8];

   // Pointers carry one extra wrap bit, so full and empty can be told apart.
   assign count     = wr_ptr_q - rd_ptr_q;
   assign empty     = (count == '0);
   assign full      = (count == c_DEPTH);
   assign busy      = !empty || (state_q != S_IDLE);
   assign baud_last = (baud_q == c_BAUD_LAST);

   // Transmit FSM. o_tx is registered from the current state, so the line
   // lags the state by one cycle. A byte popped at edge N drives the start
   // bit from edge N+1.
   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      tx_d      = 1'b1;
      pop       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               shift_d = fifo_mem[rd_ptr_q[c_AW-1:0]];
               baud_d  = '0;
               state_d = S_START;
            end
         end
         S_START: begin
            tx_d = 1'b0;
            if (baud_last) begin
               baud_d    = '0;
               bit_idx_d = '0;
               state_d   = S_DATA;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         S_DATA: begin
            tx_d = shift_q[0];
            if (baud_last) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_idx_q == 3'd7) begin
                  state_d = S_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         S_STOP: begin
            tx_d = 1'b1;
            if (baud_last) begin
               baud_d = '0;
               if (!empty) begin
                  // Back-to-back frame: no idle bit between frames.
                  pop     = 1'b1;
                  shift_d = fifo_mem[rd_ptr_q[c_AW-1:0]];
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Bus side: push/overflow, pointers, registered read data.
   // A full FIFO still accepts a push when a pop happens on the same edge.
   // A new overflow wins over a same-cycle clear.
   always_comb begin
      wr_hit   = i_mem_wr_en && (i_mem_addr == p_DATA_ADDR);
      stat_wr  = i_mem_wr_en && (i_mem_addr == p_STAT_ADDR);
      push     = wr_hit && (!full || pop);
      ovf_set  = wr_hit && full && !pop;
      wr_ptr_d = wr_ptr_q + (c_AW+1)'(push);
      rd_ptr_d = rd_ptr_q + (c_AW+1)'(pop);
      ovf_d    = ovf_q;
      if (ovf_set) begin
         ovf_d = 1'b1;
      end else if (stat_wr) begin
         ovf_d = 1'b0;
      end
      rd_valid_d = 1'b0;
      rd_data_d  = '0;
      if (i_mem_addr == p_STAT_ADDR) begin
         rd_valid_d = 1'b1;
         rd_data_d  = {12'b0, ovf_q, busy, empty, full};
      end else if (i_mem_addr == p_DATA_ADDR) begin
         rd_valid_d = 1'b1;
         rd_data_d  = 16'(count);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= S_IDLE;
         baud_q     <= '0;
         bit_idx_q  <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         ovf_q      <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         ovf_q      <= ovf_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   // FIFO storage needs no reset; the pointers define which entries are valid.
   always_ff @(posedge i_clk) begin
      if (!i_rst && push) begin
         fifo_mem[wr_ptr_q[c_AW-1:0]] <= i_mem_wr_data[7:0];
      end
   end

   assign o_tx          = tx_q;
   assign o_busy        = busy;
   assign o_rd_valid    = rd_valid_q;
   assign o_mem_rd_data = rd_data_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx
//   Bench for mmio_uart_tx with p_CLK_DIV=4 and p_FIFO_DEPTH=4.
//   A frame-level reference model tracks the queue of waiting bytes and when
//   each frame starts and ends. Every tick it pushes the expected
//   {busy, rd_valid, rd_data} into exp_q. For every byte it sends, it pushes
//   the byte and its start cycle into the TX queues. One monitor compares the
//   bus outputs. A second monitor decodes o_tx frames.
module tb_mmio_uart_tx;

   localparam int          DIV    = 4;
   localparam int          DEPTH  = 4;
   localparam int          FRAME  = 10 * DIV;
   localparam logic [15:0] DATA_A = 16'hFFFE;
   localparam logic [15:0] STAT_A = 16'hFFFD;

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] addr = '0;
   logic [15:0] wdata = '0;
   logic        we = 1'b0;
   logic [15:0] rd_data;
   logic        rd_valid, tx, busy;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   mmio_uart_tx #(
      .p_CLK_DIV   (DIV),
      .p_FIFO_DEPTH(DEPTH),
      .p_DATA_ADDR (DATA_A),
      .p_STAT_ADDR (STAT_A)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_mem_addr   (addr),
      .i_mem_wr_data(wdata),
      .i_mem_wr_en  (we),
      .o_mem_rd_data(rd_data),
      .o_rd_valid   (rd_valid),
      .o_tx         (tx),
      .o_busy       (busy)
   );

   // ---------------- bookkeeping ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // ---------------- reference model ----------------
   logic [7:0]  m_q[$];      // bytes waiting (not yet taken by the transmitter)
   bit          m_active = 0; // a frame is in flight
   int          m_frame_end = 0; // edge at which the current frame's stop bit ends
   bit          m_ovf = 0;
   logic [17:0] exp_q[$];    // {busy after edge, rd_valid, rd_data}
   logic [7:0]  exp_tx_q[$];
   int          exp_start_q[$];

   task automatic model_step();
      int          e;
      bit          pop, accept, busy_pre, wr_hit, stat_wr;
      logic [16:0] rd;
      logic [7:0]  b;
      e = cyc + 1;
      if (rst) begin
         m_q.delete();
         m_active = 0;
         m_ovf    = 0;
         exp_tx_q.delete();
         exp_start_q.delete();
         exp_q.push_back(18'h0);
         return;
      end
      busy_pre = (m_q.size() != 0) || m_active;
      pop      = (!m_active || e == m_frame_end) && (m_q.size() > 0);
      if (addr == DATA_A)      rd = {1'b1, 16'(m_q.size())};
      else if (addr == STAT_A) rd = {1'b1, 12'b0, m_ovf, busy_pre, m_q.size() == 0, m_q.size() == DEPTH};
      else                     rd = '0;
      wr_hit  = we && (addr == DATA_A);
      stat_wr = we && (addr == STAT_A);
      accept  = wr_hit && ((m_q.size() < DEPTH) || pop);
      if (wr_hit && !accept) m_ovf = 1;
      else if (stat_wr)      m_ovf = 0;
      if (pop) begin
         b = m_q.pop_front();
         exp_tx_q.push_back(b);
         exp_start_q.push_back(e + 1);
         m_active    = 1;
         m_frame_end = e + FRAME;
      end else if (m_active && e == m_frame_end) begin
         m_active = 0;
      end
      if (accept) m_q.push_back(wdata[7:0]);
      exp_q.push_back({(m_q.size() != 0) || m_active, rd});
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick(input bit r, input bit w, input logic [15:0] a, input logic [15:0] d);
      @(negedge clk);
      rst   = r;
      we    = w;
      addr  = a;
      wdata = d;
      model_step();
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(0, 0, 16'h0000, 16'h0000);
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      tick(0, 1, a, d);
   endtask

   task automatic rd(input logic [15:0] a);
      tick(0, 0, a, 16'h0000);
   endtask

   // ---------------- bus/busy monitor ----------------
   initial begin
      logic [17:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rd_valid", 32'(rd_valid), 32'(e[16]));
            check("rd_data", 32'(rd_data), 32'(e[15:0]));
            check("busy", 32'(busy), 32'(e[17]));
         end
      end
   end

   // ---------------- serial line monitor ----------------
   initial begin
      bit         in_frame;
      int         s, off, exp_s;
      logic [7:0] b, exp_b;
      in_frame = 0;
      s = 0;
      b = '0;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            in_frame = 0;
         end else if (!in_frame) begin
            if (tx == 1'b0) begin
               in_frame = 1;
               s = cyc;
               b = '0;
            end
         end else begin
            off = cyc - s;
            if (off == DIV / 2) check("start_bit", 32'(tx), 32'd0);
            if (off >= DIV && off < 9 * DIV && (off % DIV) == DIV / 2) b[(off - DIV) / DIV] = tx;
            if (off == 9 * DIV + DIV / 2) begin
               check("stop_bit", 32'(tx), 32'd1);
               in_frame = 0;
               n_checks++;
               if (exp_tx_q.size() == 0) begin
                  $display("FAIL frame_expected: got byte 0x%0h starting cycle %0d, required no frame", b, s);
               end else begin
                  n_pass++;
                  exp_b = exp_tx_q.pop_front();
                  exp_s = exp_start_q.pop_front();
                  check("frame_byte", 32'(b), 32'(exp_b));
                  check("frame_start_cycle", 32'(s), 32'(exp_s));
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int op;
      for (int i = 0; i < 3; i++) tick(1, 0, 16'h0000, 16'h0000);
      idle(3);

      // 1: single frame of 0x55, upper write bits ignored
      wr(DATA_A, 16'h1255);
      idle(45);

      // 2: three back-to-back frames, count read mid first frame
      wr(DATA_A, 16'h0041);
      wr(DATA_A, 16'h0042);
      wr(DATA_A, 16'h0043);
      idle(8);
      rd(DATA_A);
      idle(130);

      // 3: overflow from six consecutive writes, then status
      for (int i = 0; i < 6; i++) wr(DATA_A, 16'($urandom_range(0, 16'hFFFF)));
      rd(STAT_A);

      // 4: clear overflow, then drain to empty-only status
      wr(STAT_A, 16'($urandom));
      rd(STAT_A);
      idle(5 * FRAME + 10);
      rd(STAT_A);

      // 5: push on a full FIFO on the same edge as the STOP-end pop
      for (int i = 0; i < 5; i++) wr(DATA_A, 16'($urandom_range(0, 255)));
      idle(FRAME - 4);
      wr(DATA_A, 16'h00A7);
      rd(DATA_A);
      rd(STAT_A);
      idle(5 * FRAME + 10);
      rd(STAT_A);

      // 6: reset while DATA bit 3 is on the line, with bytes still queued
      wr(DATA_A, 16'h00C3);
      wr(DATA_A, 16'h003C);
      idle(17);
      tick(1, 0, 16'h0000, 16'h0000);
      #1;
      check("tx_after_reset", 32'(tx), 32'd1);
      idle(2);
      rd(STAT_A);
      idle(FRAME + 5);

      // 7: unmapped read/writes
      rd(16'h0010);
      wr(16'h0010, 16'h0077);
      wr(16'hFFFF, 16'h0078);
      rd(DATA_A);
      idle(3);

      // random traffic, with an occasional reset
      for (int i = 0; i < 600; i++) begin
         op = $urandom_range(0, 99);
         if (op < 25)      wr(DATA_A, 16'($urandom));
         else if (op < 30) wr(STAT_A, 16'($urandom));
         else if (op < 40) rd(DATA_A);
         else if (op < 50) rd(STAT_A);
         else if (op < 55) wr(16'($urandom_range(0, 16'hFFFC)), 16'($urandom));
         else if (op < 56) tick(1, 0, 16'h0000, 16'h0000);
         else              idle(1);
      end
      idle(6 * FRAME + 10);

      #2;
      check("tx_frames_left", 32'(exp_tx_q.size()), 32'd0);
      check("bus_expect_left", 32'(exp_q.size()), 32'd0);
      check("tx_idle_end", 32'(tx), 32'd1);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
